ddr_rd_scheduler: RTL and testbench

- Schedules reads of buffered packets back out of DDR.
- Sits between the DDR write-side completion interface (wr_ddr_cpl_*) and the DDR read-request interface (rd_ddr_*) of the AXI4 bus block.
- Stores completion descriptors (addr/len/strb) in one FIFO per local queue.
- Arbitrates round-robin among enabled, non-empty queues and issues one read request at a time, waiting for read completion before the next.

---
 rtl/ddr_rd_scheduler.sv | 222 ++++++++++++++++++++++
 tb/tb_ddr_rd_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rd_scheduler.sv
// ddr_rd_scheduler
//   Queues DDR write completions (addr/len/strb) in one descriptor FIFO per
//   local queue. Arbitrates round-robin among enabled, non-empty queues and
//   issues one DDR read request at a time. It waits for the read-complete
//   pulse before it arbitrates again.
//
// Ports
//   i_axis_clk / i_axis_rst      clock, synchronous active-high reset
//   i_wr_ddr_cpl_*, o_wr_ddr_cpl_ready
//                                descriptor push (valid/ready handshake)
//   i_queue_en                   per-queue scheduling enable (sampled in IDLE)
//   o_rd_ddr_*, i_rd_ddr_ready   read request (valid/ready handshake)
//   i_rd_ddr_cpl                 one-cycle pulse: outstanding read delivered
//   o_rd_cpl_queue_valid/_queue  one-cycle pulse naming the completed queue
//   o_queue_nempty               registered per-queue FIFO non-empty flags
//   o_desc_err                   one-cycle pulse when a descriptor is dropped
module ddr_rd_scheduler #(
    parameter int P_DDR_LOCAL_QUEUE  = 4,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int P_DESC_DEPTH       = 16
) (
    input  logic                          i_axis_clk,
    input  logic                          i_axis_rst,
    input  logic                          i_wr_ddr_cpl_valid,
    output logic                          o_wr_ddr_cpl_ready,
    input  logic [P_DDR_LOCAL_QUEUE-1:0]  i_wr_ddr_cpl_queue,
    input  logic [15:0]                   i_wr_ddr_cpl_len,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_wr_ddr_cpl_addr,
    input  logic [7:0]                    i_wr_ddr_cpl_strb,
    input  logic [P_DDR_LOCAL_QUEUE-1:0]  i_queue_en,
    output logic                          o_rd_ddr_valid,
    input  logic                          i_rd_ddr_ready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] o_rd_ddr_addr,
    output logic [15:0]                   o_rd_ddr_len,
    output logic [7:0]                    o_rd_ddr_strb,
    output logic [P_DDR_LOCAL_QUEUE-1:0]  o_rd_ddr_queue,
    input  logic                          i_rd_ddr_cpl,
    output logic                          o_rd_cpl_queue_valid,
    output logic [P_DDR_LOCAL_QUEUE-1:0]  o_rd_cpl_queue,
    output logic [P_DDR_LOCAL_QUEUE-1:0]  o_queue_nempty,
    output logic                          o_desc_err
);

    localparam int QN = P_DDR_LOCAL_QUEUE;
    localparam int QW = (QN > 1) ? $clog2(QN) : 1;
    localparam int AW = $clog2(P_DESC_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = C_M_AXI_ADDR_WIDTH + 16 + 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT_CPL
    } state_t;

    state_t state_q, state_d;

    logic [QN-1:0]                 full_w;
    logic [QN-1:0]                 push_w;
    logic [QN-1:0]                 pop_w;
    logic [QN-1:0]                 nempty_q;
    logic [DW-1:0]                 head_w [QN];
    logic                          q_onehot_w;
    logic                          desc_legal_w;
    logic                          accept_w;
    logic [DW-1:0]                 wr_data_w;

    logic [QW-1:0]                 rr_q;
    logic [QW-1:0]                 grant_idx_q;
    logic [QN-1:0]                 grant_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0] rd_addr_q;
    logic [15:0]                   rd_len_q;
    logic [7:0]                    rd_strb_q;
    logic [QN-1:0]                 rd_queue_q;
    logic                          cpl_valid_q;
    logic [QN-1:0]                 cpl_queue_q;
    logic                          desc_err_q;

    logic [QN-1:0]                 eligible_w;
    logic                          gnt_found_w;
    logic [QW-1:0]                 gnt_idx_w;

    // ------------------------------------------------------------------
    // Push path. Ready only drops for a legal one-hot queue whose FIFO is
    // full; illegal descriptors are always swallowed and flagged.
    // ------------------------------------------------------------------
    assign q_onehot_w   = (i_wr_ddr_cpl_queue != '0) &&
                          ((i_wr_ddr_cpl_queue & (i_wr_ddr_cpl_queue - QN'(1))) == '0);
    assign o_wr_ddr_cpl_ready = !(q_onehot_w && ((i_wr_ddr_cpl_queue & full_w) != '0));
    assign accept_w     = i_wr_ddr_cpl_valid && o_wr_ddr_cpl_ready;
    assign desc_legal_w = q_onehot_w && (i_wr_ddr_cpl_len != 16'd0);
    assign push_w       = (accept_w && desc_legal_w) ? i_wr_ddr_cpl_queue : '0;
    assign pop_w        = ((state_q == S_ISSUE) && i_rd_ddr_ready) ? grant_q : '0;
    assign wr_data_w    = {i_wr_ddr_cpl_addr, i_wr_ddr_cpl_len, i_wr_ddr_cpl_strb};

    // ------------------------------------------------------------------
    // Per-queue descriptor FIFOs
    // ------------------------------------------------------------------
    for (genvar g = 0; g < QN; g++) begin : g_fifo
        logic [DW-1:0] mem [P_DESC_DEPTH];
        logic [AW-1:0] wr_ptr_q;
        logic [AW-1:0] rd_ptr_q;
        logic [CW-1:0] cnt_q;

        assign full_w[g] = (cnt_q == CW'(P_DESC_DEPTH));
        assign head_w[g] = mem[rd_ptr_q];

        // Storage is not reset; only pointers and counts are.
        always_ff @(posedge i_axis_clk) begin
            if (push_w[g]) begin
                mem[wr_ptr_q] <= wr_data_w;
            end
        end

        always_ff @(posedge i_axis_clk) begin
            if (i_axis_rst) begin
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                cnt_q       <= '0;
                nempty_q[g] <= 1'b0;
            end else begin
                if (push_w[g]) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                end
                if (pop_w[g]) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
                if (push_w[g] && !pop_w[g]) begin
                    cnt_q <= cnt_q + CW'(1);
                end else if (pop_w[g] && !push_w[g]) begin
                    cnt_q <= cnt_q - CW'(1);
                end
                // Flag lags the count by one cycle (registered view).
                nempty_q[g] <= (cnt_q != '0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin search starting at rr_q (one past the last grant).
    // ------------------------------------------------------------------
    always_comb begin
        int            idx;
        logic [QW-1:0] cand;
        eligible_w  = nempty_q & i_queue_en;
        gnt_found_w = 1'b0;
        gnt_idx_w   = '0;
        idx         = 0;
        cand        = '0;
        for (int k = 0; k < QN; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= QN) begin
                idx = idx - QN;
            end
            cand = QW'(idx);
            if (!gnt_found_w && eligible_w[cand]) begin
                gnt_found_w = 1'b1;
                gnt_idx_w   = cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scheduler FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (gnt_found_w) state_d = S_LOAD;
            S_LOAD:     state_d = S_ISSUE;
            S_ISSUE:    if (i_rd_ddr_ready) state_d = S_WAIT_CPL;
            S_WAIT_CPL: if (i_rd_ddr_cpl) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_axis_clk) begin
        if (i_axis_rst) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            grant_idx_q <= '0;
            grant_q     <= '0;
            rd_addr_q   <= '0;
            rd_len_q    <= '0;
            rd_strb_q   <= '0;
            rd_queue_q  <= '0;
            cpl_valid_q <= 1'b0;
            cpl_queue_q <= '0;
            desc_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            desc_err_q  <= accept_w && !desc_legal_w;
            cpl_valid_q <= 1'b0;
            if ((state_q == S_IDLE) && gnt_found_w) begin
                grant_idx_q <= gnt_idx_w;
                grant_q     <= QN'(1) << gnt_idx_w;
            end
            // Request fields are captured once and held through ISSUE.
            if (state_q == S_LOAD) begin
                {rd_addr_q, rd_len_q, rd_strb_q} <= head_w[grant_idx_q];
                rd_queue_q <= grant_q;
            end
            if ((state_q == S_WAIT_CPL) && i_rd_ddr_cpl) begin
                cpl_valid_q <= 1'b1;
                cpl_queue_q <= grant_q;
                rr_q        <= (grant_idx_q == QW'(QN - 1)) ? '0 : grant_idx_q + QW'(1);
            end
        end
    end

    assign o_rd_ddr_valid       = (state_q == S_ISSUE);
    assign o_rd_ddr_addr        = rd_addr_q;
    assign o_rd_ddr_len         = rd_len_q;
    assign o_rd_ddr_strb        = rd_strb_q;
    assign o_rd_ddr_queue       = rd_queue_q;
    assign o_rd_cpl_queue_valid = cpl_valid_q;
    assign o_rd_cpl_queue       = cpl_queue_q;
    assign o_queue_nempty       = nempty_q;
    assign o_desc_err           = desc_err_q;

endmodule

// File: tb/tb_ddr_rd_scheduler.sv
// Directed testbench for ddr_rd_scheduler (4 queues, 32-bit addr, depth 16).
module tb_ddr_rd_scheduler;

    logic        clk;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_queue;
    logic [15:0] wr_len;
    logic [31:0] wr_addr;
    logic [7:0]  wr_strb;
    logic [3:0]  queue_en;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_addr;
    logic [15:0] rd_len;
    logic [7:0]  rd_strb;
    logic [3:0]  rd_queue;
    logic        rd_cpl;
    logic        cpl_valid;
    logic [3:0]  cpl_queue;
    logic [3:0]  nempty;
    logic        desc_err;

    int total = 0;
    int bad   = 0;

    ddr_rd_scheduler #(
        .P_DDR_LOCAL_QUEUE (4),
        .C_M_AXI_ADDR_WIDTH(32),
        .P_DESC_DEPTH      (16)
    ) dut (
        .i_axis_clk          (clk),
        .i_axis_rst          (rst),
        .i_wr_ddr_cpl_valid  (wr_valid),
        .o_wr_ddr_cpl_ready  (wr_ready),
        .i_wr_ddr_cpl_queue  (wr_queue),
        .i_wr_ddr_cpl_len    (wr_len),
        .i_wr_ddr_cpl_addr   (wr_addr),
        .i_wr_ddr_cpl_strb   (wr_strb),
        .i_queue_en          (queue_en),
        .o_rd_ddr_valid      (rd_valid),
        .i_rd_ddr_ready      (rd_ready),
        .o_rd_ddr_addr       (rd_addr),
        .o_rd_ddr_len        (rd_len),
        .o_rd_ddr_strb       (rd_strb),
        .o_rd_ddr_queue      (rd_queue),
        .i_rd_ddr_cpl        (rd_cpl),
        .o_rd_cpl_queue_valid(cpl_valid),
        .o_rd_cpl_queue      (cpl_queue),
        .o_queue_nempty      (nempty),
        .o_desc_err          (desc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; drive and sample 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [3:0] q, input logic [31:0] a,
                        input logic [15:0] l, input logic [7:0] s);
        wr_valid = 1'b1;
        wr_queue = q;
        wr_addr  = a;
        wr_len   = l;
        wr_strb  = s;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && !rd_valid; i++) begin
            tick();
        end
        check(tag, 64'(rd_valid), 64'd1);
    endtask

    // Expect one request for queue q, accept it, return the completion.
    task automatic serve(input string tag, input logic [3:0] q,
                         input logic [31:0] a, input logic [15:0] l);
        wait_valid({tag, "_valid"});
        check({tag, "_queue"}, 64'(rd_queue), 64'(q));
        check({tag, "_addr"},  64'(rd_addr),  64'(a));
        check({tag, "_len"},   64'(rd_len),   64'(l));
        tick();
        rd_cpl = 1'b1;
        tick();
        rd_cpl = 1'b0;
        check({tag, "_cplv"}, 64'(cpl_valid), 64'd1);
        check({tag, "_cplq"}, 64'(cpl_queue), 64'(q));
    endtask

    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_queue = 4'b0000;
        wr_len   = 16'd0;
        wr_addr  = 32'd0;
        wr_strb  = 8'd0;
        queue_en = 4'b1111;
        rd_ready = 1'b1;
        rd_cpl   = 1'b0;
        #1;
        do_reset();

        // Reset state
        check("rst_valid",  64'(rd_valid),  64'd0);
        check("rst_cplv",   64'(cpl_valid), 64'd0);
        check("rst_nempty", 64'(nempty),    64'd0);
        check("rst_err",    64'(desc_err),  64'd0);
        check("rst_addr",   64'(rd_addr),   64'd0);
        check("rst_queue",  64'(rd_queue),  64'd0);
        check("rst_ready0", 64'(wr_ready),  64'd1);
        wr_queue = 4'b0001;
        #1;
        check("rst_ready1", 64'(wr_ready),  64'd1);

        // Single descriptor: valid rises exactly three edges after the push
        push(4'b0010, 32'h1000, 16'd64, 8'hFF);
        check("lat_n0", 64'(rd_valid), 64'd0);
        tick();
        check("lat_n1", 64'(rd_valid), 64'd0);
        tick();
        check("lat_n2", 64'(rd_valid), 64'd0);
        tick();
        check("lat_n3",  64'(rd_valid), 64'd1);
        check("one_addr", 64'(rd_addr),  64'h1000);
        check("one_len",  64'(rd_len),   64'd64);
        check("one_strb", 64'(rd_strb),  64'hFF);
        check("one_q",    64'(rd_queue), 64'b0010);
        tick();
        check("one_drop", 64'(rd_valid), 64'd0);
        rd_cpl = 1'b1;
        tick();
        rd_cpl = 1'b0;
        check("one_cplv",   64'(cpl_valid), 64'd1);
        check("one_cplq",   64'(cpl_queue), 64'b0010);
        check("one_nempty", 64'(nempty),    64'd0);
        tick();
        check("one_cplv_end", 64'(cpl_valid), 64'd0);

        // Round-robin across four queues, two descriptors each
        do_reset();
        queue_en = 4'b0000;
        for (int r = 0; r < 2; r++) begin
            for (int q = 0; q < 4; q++) begin
                push(4'(1 << q), 32'h2000 + 32'(q * 256) + 32'(r * 16), 16'(q + 1), 8'hFF);
            end
        end
        queue_en = 4'b1111;
        for (int r = 0; r < 2; r++) begin
            for (int q = 0; q < 4; q++) begin
                serve("rr", 4'(1 << q), 32'h2000 + 32'(q * 256) + 32'(r * 16), 16'(q + 1));
            end
        end

        // Backpressure / full
        do_reset();
        queue_en = 4'b0000;
        rd_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push(4'b0010, 32'h3000 + 32'(i * 64), 16'(i + 1), 8'h0F);
        end
        wr_valid = 1'b1;
        wr_queue = 4'b0010;
        #1;
        check("full_ready_q1", 64'(wr_ready), 64'd0);
        wr_queue = 4'b0100;
        wr_addr  = 32'h4000;
        wr_len   = 16'd8;
        #1;
        check("full_ready_q2", 64'(wr_ready), 64'd1);
        tick();
        wr_valid = 1'b0;
        tick();
        tick();
        check("full_nempty", 64'(nempty), 64'b0110);
        queue_en = 4'b0010;
        wait_valid("bp_valid");
        check("bp_addr", 64'(rd_addr), 64'h3000);
        check("bp_len",  64'(rd_len),  64'd1);
        tick();
        tick();
        tick();
        check("bp_hold_valid", 64'(rd_valid), 64'd1);
        check("bp_hold_addr",  64'(rd_addr),  64'h3000);
        check("bp_hold_q",     64'(rd_queue), 64'b0010);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("bp_popped", 64'(rd_valid), 64'd0);
        wr_valid = 1'b1;
        wr_queue = 4'b0010;
        wr_addr  = 32'h5000;
        wr_len   = 16'd4;
        #1;
        check("cnt15_ready", 64'(wr_ready), 64'd1);
        tick();
        check("cnt16_ready", 64'(wr_ready), 64'd0);
        wr_valid = 1'b0;
        rd_cpl   = 1'b1;
        tick();
        rd_cpl   = 1'b0;
        check("bp_cplq", 64'(cpl_queue), 64'b0010);
        rd_ready = 1'b1;

        // Illegal descriptors are swallowed and flagged
        do_reset();
        queue_en = 4'b1111;
        push(4'b0000, 32'h6000, 16'd64, 8'hFF);
        check("err_zero", 64'(desc_err), 64'd1);
        push(4'b0110, 32'h6100, 16'd64, 8'hFF);
        check("err_multi", 64'(desc_err), 64'd1);
        push(4'b0001, 32'h6200, 16'd0, 8'hFF);
        check("err_len0", 64'(desc_err), 64'd1);
        tick();
        check("err_end", 64'(desc_err), 64'd0);
        for (int i = 0; i < 5; i++) tick();
        check("err_nempty", 64'(nempty),   64'd0);
        check("err_valid",  64'(rd_valid), 64'd0);

        // Enable gating
        do_reset();
        queue_en = 4'b0000;
        push(4'b0001, 32'h7000, 16'd16, 8'hFF);
        push(4'b0100, 32'h7400, 16'd16, 8'hFF);
        queue_en = 4'b0100;
        serve("en_q2", 4'b0100, 32'h7400, 16'd16);
        for (int i = 0; i < 6; i++) tick();
        check("en_q0_blocked", 64'(rd_valid), 64'd0);
        queue_en = 4'b0101;
        serve("en_q0", 4'b0001, 32'h7000, 16'd16);

        // Reset while waiting for completion
        do_reset();
        queue_en = 4'b1111;
        push(4'b1000, 32'h8000, 16'd32, 8'hFF);
        push(4'b1000, 32'h8100, 16'd32, 8'hFF);
        wait_valid("mid_valid");
        tick();
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        rd_cpl = 1'b1;
        tick();
        rd_cpl = 1'b0;
        check("mid_cplv",   64'(cpl_valid), 64'd0);
        check("mid_nempty", 64'(nempty),    64'd0);
        check("mid_valid0", 64'(rd_valid),  64'd0);
        for (int i = 0; i < 4; i++) tick();
        check("mid_valid1", 64'(rd_valid),  64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
